sgf_mult_arbiter: RTL and testbench

Shares one registered significand multiplier between two requesters, for example the FP multiply unit and a second datapath client. Arbitration is round-robin by default, with a fixed-priority option. The block registers the granted operands and multiplies them in a two-stage pipeline. Each result returns tagged with the requester ID. It sits between the requesters' operand-issue logic and their normalisation/rounding stages.

---
 rtl/sgf_mult_pkg.sv | 15 +
 rtl/sgf_rr_arbiter.sv | 58 +++++
 rtl/sgf_mult_arbiter.sv | 97 +++++++++
 tb/tb_sgf_mult_arbiter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/sgf_mult_pkg.sv
// Shared constants and types for the shared significand multiplier.
// Optional build macro: SGF_ARB_FIXED_PRIO_EN (fixed priority, requester 0 wins).
package sgf_mult_pkg;

    localparam int unsigned SGF_ID_W     = 1;   // requester ID width
    localparam int unsigned SGF_N_REQ    = 2;   // number of requesters
    localparam int unsigned SGF_PIPE_LAT = 2;   // accept-to-result latency in cycles

    // Round-robin pointer: which requester wins the next contended cycle
    typedef enum logic {
        PRIO_0 = 1'b0,
        PRIO_1 = 1'b1
    } prio_t;

endpackage

// File: rtl/sgf_rr_arbiter.sv
// Two-requester arbiter for the shared significand multiplier.
// Round-robin by default; define SGF_ARB_FIXED_PRIO_EN for fixed priority
// (requester 0 always wins, no pointer state).
module sgf_rr_arbiter
    import sgf_mult_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SGF_N_REQ-1:0] valid,
    output logic [SGF_N_REQ-1:0] grant,
    output logic                 accept
);

`ifdef SGF_ARB_FIXED_PRIO_EN

    // Fixed priority: requester 1 only wins when requester 0 is idle
    always_comb begin
        grant  = '0;
        accept = 1'b0;
        if (!rst) begin
            grant[0] = valid[0];
            grant[1] = valid[1] & ~valid[0];
            accept   = |grant;
        end
    end

`else

    prio_t r_prio;
    prio_t w_prio_next;

    // Pointer register: starts at requester 0 after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio <= PRIO_0;
        end else begin
            r_prio <= w_prio_next;
        end
    end

    // Grant decode and pointer update: after every accept the loser gets priority
    always_comb begin
        grant       = '0;
        accept      = 1'b0;
        w_prio_next = r_prio;
        if (!rst) begin
            grant[0] = valid[0] & (~valid[1] | (r_prio == PRIO_0));
            grant[1] = valid[1] & ~grant[0];
            accept   = |grant;
            if (accept) begin
                w_prio_next = grant[0] ? PRIO_1 : PRIO_0;
            end
        end
    end

`endif

endmodule

// File: rtl/sgf_mult_arbiter.sv
// Shared two-stage significand multiplier with two arbitrated requesters.
// Results return in issue order, tagged with the requester ID.
// Optional build macro: SGF_ARB_FIXED_PRIO_EN (handled in sgf_rr_arbiter).
module sgf_mult_arbiter
    import sgf_mult_pkg::*;
#(
    parameter int unsigned W_Sgf = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [W_Sgf:0]       req0_a,
    input  logic [W_Sgf:0]       req0_b,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [W_Sgf:0]       req1_a,
    input  logic [W_Sgf:0]       req1_b,
    output logic                 res_valid,
    output logic                 res_id,
    output logic [2*W_Sgf+1:0]   res_data,
    output logic                 busy
);

    localparam int unsigned PW = 2 * W_Sgf + 2;

    logic [SGF_N_REQ-1:0] w_grant;
    logic                 w_accept;
    logic [W_Sgf:0]       w_a;
    logic [W_Sgf:0]       w_b;
    logic [PW-1:0]        w_prod;

    logic                 r_s1_valid;
    logic [SGF_ID_W-1:0]  r_s1_id;
    logic [W_Sgf:0]       r_s1_a;
    logic [W_Sgf:0]       r_s1_b;
    logic                 r_s2_valid;
    logic [SGF_ID_W-1:0]  r_s2_id;
    logic [PW-1:0]        r_s2_prod;

    sgf_rr_arbiter u_arb (
        .clk    (clk),
        .rst    (rst),
        .valid  ({req1_valid, req0_valid}),
        .grant  (w_grant),
        .accept (w_accept)
    );

    assign req0_ready = w_grant[0];
    assign req1_ready = w_grant[1];

    // Operand mux for the granted requester
    always_comb begin
        w_a = w_grant[1] ? req1_a : req0_a;
        w_b = w_grant[1] ? req1_b : req0_b;
    end

    assign w_prod = PW'(r_s1_a) * PW'(r_s1_b);

    // S1: capture granted operands; operand registers hold when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_id    <= '0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_id <= SGF_ID_W'(w_grant[1]);
                r_s1_a  <= w_a;
                r_s1_b  <= w_b;
            end
        end
    end

    // S2: full-width product; result and ID hold while no operation arrives
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_id    <= '0;
            r_s2_prod  <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_id   <= r_s1_id;
                r_s2_prod <= w_prod;
            end
        end
    end

    assign res_valid = r_s2_valid;
    assign res_id    = r_s2_id[0];
    assign res_data  = r_s2_prod;
    assign busy      = r_s1_valid | r_s2_valid;

endmodule

// File: tb/tb_sgf_mult_arbiter.sv
// Self-checking bench for sgf_mult_arbiter: two instances (W_Sgf=23 and 52)
// share valid/reset stimulus and are checked against a transaction-level model.
module tb_sgf_mult_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic v0  = 1'b0;
    logic v1  = 1'b0;

    logic [23:0]  a0s = '0, b0s = '0, a1s = '0, b1s = '0;
    logic [52:0]  a0d = '0, b0d = '0, a1d = '0, b1d = '0;

    logic         rdy0s, rdy1s, rvs, rids, busys;
    logic [47:0]  rds;
    logic         rdy0d, rdy1d, rvd, ridd, busyd;
    logic [105:0] rdd;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: expected contents of each pipeline stage
    typedef struct {
        bit           v;
        bit           id;
        logic [47:0]  ps;
        logic [105:0] pd;
    } stg_t;

    stg_t m_s1, m_s2;
    bit           m_turn;     // who wins the next contended cycle
    bit           m_id;       // held result ID
    logic [47:0]  m_ds;       // held result, single
    logic [105:0] m_dd;       // held result, double

    always #5 clk = ~clk;

    sgf_mult_arbiter #(.W_Sgf(23)) dut_s (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_ready(rdy0s), .req0_a(a0s), .req0_b(b0s),
        .req1_valid(v1), .req1_ready(rdy1s), .req1_a(a1s), .req1_b(b1s),
        .res_valid(rvs), .res_id(rids), .res_data(rds), .busy(busys)
    );

    sgf_mult_arbiter #(.W_Sgf(52)) dut_d (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_ready(rdy0d), .req0_a(a0d), .req0_b(b0d),
        .req1_valid(v1), .req1_ready(rdy1d), .req1_a(a1d), .req1_b(b1d),
        .res_valid(rvd), .res_id(ridd), .res_data(rdd), .busy(busyd)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [52:0] rnd53();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[52:0];
    endfunction

    task automatic model_reset();
        m_s1   = '{v: 1'b0, id: 1'b0, ps: '0, pd: '0};
        m_s2   = m_s1;
        m_turn = 1'b0;
        m_id   = 1'b0;
        m_ds   = '0;
        m_dd   = '0;
    endtask

    // One clock cycle: check outputs, drive inputs, check readys, advance model
    task automatic step(input bit iv0, input bit iv1, input bit ir,
                        input logic [23:0] x0, input logic [23:0] y0,
                        input logic [23:0] x1, input logic [23:0] y1);
        bit   g0, g1;
        stg_t nw;
        @(negedge clk);
        check("res_valid_s", rvs,   m_s2.v);
        check("res_id_s",    rids,  m_id);
        check("res_data_s",  rds,   m_ds);
        check("busy_s",      busys, m_s1.v | m_s2.v);
        check("res_valid_d", rvd,   m_s2.v);
        check("res_id_d",    ridd,  m_id);
        check("res_data_d",  rdd,   m_dd);
        check("busy_d",      busyd, m_s1.v | m_s2.v);

        rst = ir; v0 = iv0; v1 = iv1;
        a0s = x0; b0s = y0; a1s = x1; b1s = y1;
        a0d = rnd53(); b0d = rnd53(); a1d = rnd53(); b1d = rnd53();
        #1;
        g0 = 1'b0; g1 = 1'b0;
        if (!ir) begin
`ifdef SGF_ARB_FIXED_PRIO_EN
            g0 = iv0;
            g1 = iv1 && !iv0;
`else
            if (iv0 && iv1) begin
                g0 = (m_turn == 1'b0);
                g1 = (m_turn == 1'b1);
            end else begin
                g0 = iv0;
                g1 = iv1;
            end
`endif
        end
        check("req0_ready_s", rdy0s, g0);
        check("req1_ready_s", rdy1s, g1);
        check("req0_ready_d", rdy0d, g0);
        check("req1_ready_d", rdy1d, g1);

        if (ir) begin
            model_reset();
        end else begin
            nw.v  = g0 | g1;
            nw.id = g1;
            nw.ps = g1 ? 48'(x1) * 48'(y1) : 48'(x0) * 48'(y0);
            nw.pd = g1 ? 106'(a1d) * 106'(b1d) : 106'(a0d) * 106'(b0d);
            if (nw.v) m_turn = g0;   // loser of this accept gets the next tie
            if (m_s1.v) begin
                m_id = m_s1.id;
                m_ds = m_s1.ps;
                m_dd = m_s1.pd;
            end
            m_s2 = m_s1;
            m_s1 = nw;
        end
    endtask

    initial begin
        bit rv0, rv1;
        int ops;
        model_reset();
        repeat (2) @(posedge clk);

        // Reset state then single op on requester 0
        step(1, 0, 0, 24'h800000, 24'h800000, '0, '0);
        step(0, 0, 0, '0, '0, '0, '0);
        step(0, 0, 0, '0, '0, '0, '0);
        step(0, 0, 0, '0, '0, '0, '0);
        check("single_op_const", rds, 48'h400000000000);

        // Max operands on requester 1
        step(0, 1, 0, '0, '0, 24'hFFFFFF, 24'hFFFFFF);
        step(0, 0, 0, '0, '0, '0, '0);
        step(0, 0, 0, '0, '0, '0, '0);
        step(0, 0, 0, '0, '0, '0, '0);
        check("max_op_const", rds, 48'hFFFFFE000001);
        check("max_op_id", rids, 1'b1);

        // Contention: both valid for four cycles
        for (int unsigned i = 0; i < 4; i++) begin
            step(1, 1, 0, 24'(32'h10 + i), 24'(32'h300 + i), 24'(32'h5000 + i), 24'(32'h70000 + i));
        end
        repeat (3) step(0, 0, 0, '0, '0, '0, '0);

        // Reset mid-flight: accept req1, then req0, then reset
        step(0, 1, 0, '0, '0, 24'h123456, 24'h654321);
        step(1, 0, 0, 24'hABCDEF, 24'h0FEDCB, '0, '0);
        step(0, 0, 1, '0, '0, '0, '0);
        step(1, 1, 0, 24'h000011, 24'h000022, 24'h000033, 24'h000044);
        repeat (3) step(0, 0, 0, '0, '0, '0, '0);

        // Idle gaps on requester 0
        for (int unsigned i = 0; i < 8; i++) begin
            step(i[0] == 1'b0, 0, 0, 24'($urandom()), 24'($urandom()), '0, '0);
        end

        // Randomized traffic until 1000 ops accepted
        ops = 0;
        for (int unsigned i = 0; i < 4000 && ops < 1000; i++) begin
            rv0 = ($urandom_range(0, 3) != 0);
            rv1 = ($urandom_range(0, 2) != 0);
            if (rv0 || rv1) ops++;
            step(rv0, rv1, ($urandom_range(0, 199) == 0),
                 24'($urandom()), 24'($urandom()), 24'($urandom()), 24'($urandom()));
        end
        repeat (3) step(0, 0, 0, '0, '0, '0, '0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
